// File: rtl/leaf_router_pkg.sv
// Shared address-field layout and destination decode helpers for the leaf router.
package leaf_router_pkg;
  localparam int ADDR_W   = 6;
  localparam int GRP_MSB  = 5;
  localparam int GRP_LSB  = 2;
  localparam int LEAF_MSB = 1;
  localparam int LEAF_LSB = 0;

  function automatic logic is_local(input logic [ADDR_W-1:0]          dest,
                                    input logic [GRP_MSB-GRP_LSB:0]   grp,
                                    input logic [LEAF_MSB-LEAF_LSB:0] id);
    return (dest[GRP_MSB:GRP_LSB] == grp) && (dest[LEAF_MSB:LEAF_LSB] == id);
  endfunction

  // n is 1, 2 or 4, so the modulo reduces to a mask on the leaf field
  function automatic logic [LEAF_MSB-LEAF_LSB:0] spine_sel(input logic [ADDR_W-1:0] dest,
                                                           input int n);
    logic [ADDR_W-1:0] m;
    m = ADDR_W'(n - 1);
    return 2'(dest & m);
  endfunction
endpackage

// File: rtl/leaf_router_buffered_sync_fifo.sv
// Synchronous FIFO; head entry is visible on rdata the cycle after it is written.
module sync_fifo #(
  parameter int W     = 22,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // a pop in the same cycle does not open a slot for a push while full
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/leaf_router_buffered.sv
// Buffered leaf router: one GPU port and NUM_SPINES spine links, ingress FIFOs,
// round-robin GPU egress arbitration, uplink steering and misroute dropping.
module leaf_router_buffered
  import leaf_router_pkg::*;
#(
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter int         NUM_SPINES = 4,
  parameter logic [3:0] GROUP_ID   = 4'b0010,
  parameter int         ROUTER_ID  = 3,
  parameter int         GW         = $clog2(NUM_SPINES+1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  arb_enable,
  input  logic [DWIDTH-1:0]                     gpu_in_data,
  input  logic                                  gpu_in_valid,
  input  logic [ADDR_W-1:0]                     gpu_dest_addr,
  output logic                                  gpu_in_ready,
  output logic [DWIDTH-1:0]                     gpu_out_data,
  output logic                                  gpu_out_valid,
  input  logic                                  gpu_out_ready,
  input  logic [NUM_SPINES-1:0][DWIDTH-1:0]     spine_in_data,
  input  logic [NUM_SPINES-1:0]                 spine_in_valid,
  input  logic [NUM_SPINES-1:0][ADDR_W-1:0]     spine_in_dest,
  output logic [NUM_SPINES-1:0]                 spine_in_ready,
  output logic [NUM_SPINES-1:0][DWIDTH-1:0]     spine_out_data,
  output logic [NUM_SPINES-1:0]                 spine_out_valid,
  output logic [NUM_SPINES-1:0][ADDR_W-1:0]     spine_out_dest,
  input  logic [NUM_SPINES-1:0]                 spine_out_ready,
  output logic [NUM_SPINES-1:0]                 spine_fifo_full,
  output logic [NUM_SPINES-1:0]                 spine_fifo_empty,
  output logic                                  gpu_fifo_full,
  output logic                                  gpu_fifo_empty,
  output logic                                  crossbar_busy,
  output logic [GW-1:0]                         current_grant,
  output logic [7:0]                            drop_count
);
  localparam int         NR      = NUM_SPINES + 1;
  localparam logic [1:0] LEAF_ID = ROUTER_ID[1:0];

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DWIDTH-1:0] data;
  } flit_t;

  flit_t [NUM_SPINES-1:0] s_head;
  logic  [NUM_SPINES-1:0] s_pop, s_local, s_drop, sp_load;
  flit_t                  g_head;
  logic                   g_pop, g_local;
  logic  [1:0]            g_spine;
  logic  [NR-1:0]         req;
  logic  [GW-1:0]         rr_ptr, win;
  logic                   win_vld, gpu_load;
  logic  [DWIDTH-1:0]     win_data;
  logic  [8:0]            drop_sum;

  sync_fifo #(.W($bits(flit_t)), .DEPTH(FIFO_DEPTH)) u_gpu_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (gpu_in_valid),
    .wdata ({gpu_dest_addr, gpu_in_data}),
    .pop   (g_pop),
    .rdata (g_head),
    .full  (gpu_fifo_full),
    .empty (gpu_fifo_empty)
  );

  assign gpu_in_ready = !gpu_fifo_full;
  assign g_local      = is_local(g_head.dest, GROUP_ID, LEAF_ID);
  assign g_spine      = spine_sel(g_head.dest, NUM_SPINES);

  for (genvar k = 0; k < NUM_SPINES; k++) begin : g_lane
    sync_fifo #(.W($bits(flit_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (spine_in_valid[k]),
      .wdata ({spine_in_dest[k], spine_in_data[k]}),
      .pop   (s_pop[k]),
      .rdata (s_head[k]),
      .full  (spine_fifo_full[k]),
      .empty (spine_fifo_empty[k])
    );
    assign spine_in_ready[k] = !spine_fifo_full[k];
    assign s_local[k] = is_local(s_head[k].dest, GROUP_ID, LEAF_ID);
    // misrouted heads leave without arbitration, but not while frozen
    assign s_drop[k]  = arb_enable && !spine_fifo_empty[k] && !s_local[k];
    assign s_pop[k]   = s_drop[k] || (gpu_load && (win == GW'(k)));
    // the GPU FIFO is the only source for spine egress
    assign sp_load[k] = arb_enable && !gpu_fifo_empty && !g_local && (g_spine == 2'(k)) &&
                        (!spine_out_valid[k] || spine_out_ready[k]);
  end

  assign req   = {!gpu_fifo_empty && g_local, ~spine_fifo_empty & s_local};
  assign g_pop = (|sp_load) || (gpu_load && (win == GW'(NUM_SPINES)));

  // round-robin search starting at rr_ptr, wrapping at NR
  always_comb begin
    int           idx;
    logic [GW-1:0] sel;
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int i = 0; i < NR; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NR) idx = idx - NR;
      sel = GW'(idx);
      if (!win_vld && req[sel]) begin
        win_vld = 1'b1;
        win     = sel;
      end
    end
  end

  assign gpu_load = arb_enable && win_vld && (!gpu_out_valid || gpu_out_ready);

  always_comb begin
    win_data = g_head.data;
    for (int k = 0; k < NUM_SPINES; k++)
      if (win == GW'(k)) win_data = s_head[k].data;
  end

  always_comb begin
    drop_sum = {1'b0, drop_count};
    for (int k = 0; k < NUM_SPINES; k++) drop_sum = drop_sum + 9'(s_drop[k]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpu_out_valid   <= 1'b0;
      gpu_out_data    <= '0;
      rr_ptr          <= '0;
      current_grant   <= '0;
      drop_count      <= '0;
      spine_out_valid <= '0;
      spine_out_data  <= '0;
      spine_out_dest  <= '0;
    end else begin
      if (gpu_load) begin
        gpu_out_valid <= 1'b1;
        gpu_out_data  <= win_data;
        current_grant <= win;
        rr_ptr        <= (int'(win) == NR-1) ? '0 : win + GW'(1);
      end else if (gpu_out_ready) begin
        gpu_out_valid <= 1'b0;
      end
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      for (int k = 0; k < NUM_SPINES; k++) begin
        if (sp_load[k]) begin
          spine_out_valid[k] <= 1'b1;
          spine_out_data[k]  <= g_head.data;
          spine_out_dest[k]  <= g_head.dest;
        end else if (spine_out_ready[k]) begin
          spine_out_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign crossbar_busy = gpu_out_valid || (|spine_out_valid);
endmodule

// File: tb/tb_leaf_router_buffered.sv
// Bench for leaf_router_buffered: directed table, multi-cycle corner sequences and
// randomized traffic scored against per-destination expectation queues.
module tb_leaf_router_buffered;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam logic [5:0] LOCAL = 6'b001011;

  logic clk = 1'b0;
  logic reset, arb_enable;
  logic [DW-1:0] gpu_in_data;
  logic gpu_in_valid;
  logic [5:0] gpu_dest_addr;
  logic gpu_in_ready;
  logic [DW-1:0] gpu_out_data;
  logic gpu_out_valid, gpu_out_ready;
  logic [N-1:0][DW-1:0] spine_in_data;
  logic [N-1:0] spine_in_valid;
  logic [N-1:0][5:0] spine_in_dest;
  logic [N-1:0] spine_in_ready;
  logic [N-1:0][DW-1:0] spine_out_data;
  logic [N-1:0] spine_out_valid;
  logic [N-1:0][5:0] spine_out_dest;
  logic [N-1:0] spine_out_ready;
  logic [N-1:0] spine_fifo_full, spine_fifo_empty;
  logic gpu_fifo_full, gpu_fifo_empty, crossbar_busy;
  logic [2:0] current_grant;
  logic [7:0] drop_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  leaf_router_buffered dut (
    .clk(clk), .reset(reset), .arb_enable(arb_enable),
    .gpu_in_data(gpu_in_data), .gpu_in_valid(gpu_in_valid), .gpu_dest_addr(gpu_dest_addr),
    .gpu_in_ready(gpu_in_ready), .gpu_out_data(gpu_out_data), .gpu_out_valid(gpu_out_valid),
    .gpu_out_ready(gpu_out_ready), .spine_in_data(spine_in_data), .spine_in_valid(spine_in_valid),
    .spine_in_dest(spine_in_dest), .spine_in_ready(spine_in_ready), .spine_out_data(spine_out_data),
    .spine_out_valid(spine_out_valid), .spine_out_dest(spine_out_dest),
    .spine_out_ready(spine_out_ready), .spine_fifo_full(spine_fifo_full),
    .spine_fifo_empty(spine_fifo_empty), .gpu_fifo_full(gpu_fifo_full),
    .gpu_fifo_empty(gpu_fifo_empty), .crossbar_busy(crossbar_busy),
    .current_grant(current_grant), .drop_count(drop_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    gpu_in_valid = 1'b0; gpu_in_data = '0; gpu_dest_addr = '0;
    spine_in_valid = '0; spine_in_data = '0; spine_in_dest = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; arb_enable = 1'b1; gpu_out_ready = 1'b1; spine_out_ready = '1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // directed single-flit vectors; port 4 = GPU egress, 0..3 = spine egress, -1 = dropped
  typedef struct { int src; logic [5:0] dest; logic [15:0] data; int port; } vec_t;
  vec_t tbl[11];

  // scoreboard for random traffic
  logic [15:0] q_g [5][$];
  logic [21:0] q_sp[4][$];
  int seq[5];
  int exp_drops;
  logic held_vld;
  logic [15:0] held_data;

  task automatic rand_cycle(input bit active);
    int src;
    logic [5:0] d;
    @(negedge clk);
    if (held_vld) chk("rnd_hold", {gpu_out_valid, gpu_out_data}, {1'b1, held_data});
    gpu_out_ready   = active ? ($urandom_range(3) != 0) : 1'b1;
    spine_out_ready = active ? 4'($urandom) | 4'($urandom) : '1;
    arb_enable      = active ? ($urandom_range(9) != 0) : 1'b1;
    held_vld  = gpu_out_valid && !gpu_out_ready;
    held_data = gpu_out_data;
    if (gpu_out_valid && gpu_out_ready) begin
      src = int'(gpu_out_data[15:13]);
      if (src > 4 || q_g[src].size() == 0) begin
        nvec++; nerr++;
        $display("FAIL rnd_gpu_src: got flit %0h, expected none from source %0d", gpu_out_data, src);
      end else chk("rnd_gpu_data", gpu_out_data, q_g[src].pop_front());
    end
    for (int k = 0; k < N; k++)
      if (spine_out_valid[k] && spine_out_ready[k]) begin
        if (q_sp[k].size() == 0) begin
          nvec++; nerr++;
          $display("FAIL rnd_spine_extra: spine %0d got %0h, expected nothing", k, spine_out_data[k]);
        end else chk("rnd_spine_flit", {spine_out_dest[k], spine_out_data[k]}, q_sp[k].pop_front());
      end
    clear_inputs();
    if (active) begin
      gpu_in_valid = ($urandom_range(1) == 1);
      d = ($urandom_range(2) == 0) ? LOCAL : 6'($urandom);
      gpu_dest_addr = d;
      gpu_in_data = {3'd4, 13'(seq[4])};
      if (gpu_in_valid && gpu_in_ready) begin
        if (d == LOCAL) q_g[4].push_back(gpu_in_data);
        else q_sp[d[1:0] % N].push_back({d, gpu_in_data});
        seq[4]++;
      end
      for (int k = 0; k < N; k++) begin
        spine_in_valid[k] = ($urandom_range(2) == 0);
        d = ($urandom_range(2) != 0) ? LOCAL : 6'($urandom);
        spine_in_dest[k] = d;
        spine_in_data[k] = {3'(k), 13'(seq[k])};
        if (spine_in_valid[k] && spine_in_ready[k]) begin
          if (d == LOCAL) q_g[k].push_back(spine_in_data[k]);
          else exp_drops++;
          seq[k]++;
        end
      end
    end
  endtask

  initial begin
    int lg, drops;
    bit saw;
    reset = 1'b1; arb_enable = 1'b1; gpu_out_ready = 1'b1; spine_out_ready = '1;
    clear_inputs();
    held_vld = 1'b0; held_data = '0;

    tbl[0]  = '{4, 6'b001011, 16'hA5A5, 4};
    tbl[1]  = '{4, 6'b010010, 16'h1234, 2};
    tbl[2]  = '{4, 6'b001000, 16'h1111, 0};
    tbl[3]  = '{4, 6'b111101, 16'h2222, 1};
    tbl[4]  = '{4, 6'b000011, 16'h3333, 3};
    tbl[5]  = '{2, 6'b001011, 16'h4444, 4};
    tbl[6]  = '{0, 6'b001011, 16'h5555, 4};
    tbl[7]  = '{3, 6'b000111, 16'h6666, -1};
    tbl[8]  = '{1, 6'b001011, 16'h7777, 4};
    tbl[9]  = '{3, 6'b001011, 16'h8888, 4};
    tbl[10] = '{1, 6'b001111, 16'h9999, -1};

    // reset state
    do_reset();
    #1;
    chk("rst_valids", {gpu_out_valid, spine_out_valid, crossbar_busy}, 0);
    chk("rst_gpu_data", gpu_out_data, 0);
    chk("rst_spine_data", spine_out_data, 0);
    chk("rst_spine_dest", spine_out_dest, 0);
    chk("rst_grant_drop", {current_grant, drop_count}, 0);
    chk("rst_status", {gpu_fifo_empty, spine_fifo_empty, gpu_fifo_full, spine_fifo_full}, 10'b1_1111_0_0000);
    chk("rst_ready", {gpu_in_ready, spine_in_ready}, 5'b11111);

    // directed table
    lg = 0; drops = 0;
    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      if (tbl[v].src == 4) begin
        gpu_in_valid = 1'b1; gpu_dest_addr = tbl[v].dest; gpu_in_data = tbl[v].data;
      end else begin
        spine_in_valid[tbl[v].src] = 1'b1;
        spine_in_dest[tbl[v].src]  = tbl[v].dest;
        spine_in_data[tbl[v].src]  = tbl[v].data;
      end
      @(negedge clk);
      clear_inputs();
      @(posedge clk); #1;
      if (tbl[v].port == 4) begin
        lg = tbl[v].src;
        chk("tbl_gpu_valid", gpu_out_valid, 1);
        chk("tbl_gpu_data", gpu_out_data, tbl[v].data);
        chk("tbl_no_spine", spine_out_valid, 0);
      end else if (tbl[v].port >= 0) begin
        chk("tbl_spine_valid", spine_out_valid, 4'b0001 << tbl[v].port);
        chk("tbl_spine_data", spine_out_data[tbl[v].port], tbl[v].data);
        chk("tbl_spine_dest", spine_out_dest[tbl[v].port], tbl[v].dest);
        chk("tbl_no_gpu", gpu_out_valid, 0);
      end else begin
        drops++;
        chk("tbl_drop_quiet", {gpu_out_valid, spine_out_valid}, 0);
      end
      chk("tbl_drop_count", drop_count, drops);
      chk("tbl_grant", current_grant, lg);
    end

    // fairness: four spines each push three local flits together
    do_reset();
    for (int cyc = 0; cyc <= 12; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        spine_in_valid[k] = (cyc < 3);
        spine_in_dest[k]  = LOCAL;
        spine_in_data[k]  = {4'(k), 12'(cyc)};
      end
      @(posedge clk); #1;
      if (cyc >= 1) begin
        chk("fair_valid", gpu_out_valid, 1);
        chk("fair_data", gpu_out_data, {4'((cyc-1) % 4), 12'((cyc-1) / 4)});
      end
    end
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
    chk("fair_idle", gpu_out_valid, 0);

    // backpressure: 9 flits on spine 1 while the GPU egress is stalled
    do_reset();
    @(negedge clk); gpu_out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      spine_in_valid[1] = 1'b1; spine_in_dest[1] = LOCAL; spine_in_data[1] = 16'(32'hB000 + i);
      @(negedge clk);
    end
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready", spine_in_ready[1], 0);
      chk("bp_full", spine_fifo_full[1], 1);
      chk("bp_hold", {gpu_out_valid, gpu_out_data}, {1'b1, 16'hB000});
    end
    gpu_out_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      @(posedge clk); #1;
      chk("bp_drain", {gpu_out_valid, gpu_out_data}, {1'b1, 16'(32'hB000 + i)});
    end
    @(posedge clk); #1;
    chk("bp_done", {gpu_out_valid, spine_fifo_empty[1]}, 2'b01);

    // misroute: 300 flits to a foreign group on spine 0
    do_reset();
    saw = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (gpu_out_valid) saw = 1'b1;
      if (i == 101) chk("mis_count_mid", drop_count, 100);
      spine_in_valid[0] = 1'b1; spine_in_dest[0] = 6'b001100; spine_in_data[0] = 16'(i);
    end
    @(negedge clk); clear_inputs();
    repeat (3) begin @(negedge clk); if (gpu_out_valid) saw = 1'b1; end
    chk("mis_no_gpu", saw, 0);
    chk("mis_saturate", drop_count, 255);

    // simultaneous discards on all spines in one cycle
    do_reset();
    @(negedge clk);
    spine_in_valid = '1; spine_in_dest = '0;
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
    chk("multi_drop", drop_count, 4);

    // arb_enable low freezes pops, loads and discards; pushes continue
    do_reset();
    @(negedge clk);
    arb_enable = 1'b0;
    gpu_in_valid = 1'b1; gpu_dest_addr = LOCAL; gpu_in_data = 16'hC0DE;
    spine_in_valid[2] = 1'b1; spine_in_dest[2] = 6'b100001;
    @(negedge clk); clear_inputs();
    repeat (3) @(negedge clk);
    chk("frz_quiet", {gpu_out_valid, drop_count}, 0);
    chk("frz_queued", {gpu_fifo_empty, spine_fifo_empty[2]}, 0);
    arb_enable = 1'b1;
    @(posedge clk); #1;
    chk("frz_release", {gpu_out_valid, gpu_out_data, drop_count, current_grant}, {1'b1, 16'hC0DE, 8'd1, 3'd4});

    // reset while flits are in flight
    do_reset();
    @(negedge clk);
    gpu_out_ready = 1'b0;
    spine_in_valid[0] = 1'b1; spine_in_dest[0] = 6'b111111;
    for (int i = 0; i < 5; i++) begin
      spine_in_valid[2] = 1'b1; spine_in_dest[2] = LOCAL; spine_in_data[2] = 16'(i + 1);
      @(negedge clk);
      spine_in_valid[0] = 1'b0;
    end
    clear_inputs();
    @(negedge clk);
    chk("mid_pre", {gpu_out_valid, current_grant, drop_count, spine_fifo_empty[2]}, {1'b1, 3'd2, 8'd1, 1'b0});
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_empty", {gpu_fifo_empty, spine_fifo_empty}, 5'b11111);
    chk("mid_rst_state", {gpu_out_valid, spine_out_valid, current_grant, drop_count, gpu_out_data}, 0);
    @(negedge clk); reset = 1'b0; gpu_out_ready = 1'b1;

    // randomized traffic
    do_reset();
    exp_drops = 0;
    for (int s = 0; s < 5; s++) seq[s] = 0;
    held_vld = 1'b0;
    for (int c = 0; c < 600; c++) rand_cycle(1'b1);
    for (int c = 0; c < 120; c++) rand_cycle(1'b0);
    for (int s = 0; s < 5; s++) chk("rnd_gpu_left", q_g[s].size(), 0);
    for (int k = 0; k < N; k++) chk("rnd_spine_left", q_sp[k].size(), 0);
    chk("rnd_drops", drop_count, (exp_drops > 255) ? 255 : exp_drops);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/leaf_router_buffered.md
Name: leaf_router_buffered

Overview:
- Parametrised, buffered successor to the group leaf router.
- Connects one GPU port to NUM_SPINES spine links.
- Every port has valid/ready backpressure and a real ingress FIFO.
- Round-robin arbitration into the GPU egress, destination decode against GROUP_ID/ROUTER_ID, and a misroute drop counter.
- Instantiated once per leaf in each group.

Parameters:
- DWIDTH, 16, flit payload width.
- FIFO_DEPTH, 8, entries per ingress FIFO; power of 2, >=2.
- NUM_SPINES, 4, spine port count; one of 1, 2, 4.
- GROUP_ID, 4'b0010, this router's group; compared with dest_addr[5:2].
- ROUTER_ID, 3, this leaf's index; compared with dest_addr[1:0].
- GW, $clog2(NUM_SPINES+1), derived; grant index width.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- arb_enable  in  1  low = no new grants; held outputs stay.
- gpu_in_data / gpu_in_valid / gpu_dest_addr  in  DWIDTH / 1 / 6  GPU ingress flit.
- gpu_in_ready  out  1  equals !gpu_fifo_full.
- gpu_out_data / gpu_out_valid  out  DWIDTH / 1  GPU egress.
- gpu_out_ready  in  1  GPU egress accept.
- spine_in_data / spine_in_valid / spine_in_dest  in  NUM_SPINES*DWIDTH / NUM_SPINES / NUM_SPINES*6  flattened; spine k in slice k.
- spine_in_ready  out  NUM_SPINES  per-spine !full.
- spine_out_data / spine_out_valid / spine_out_dest  out  NUM_SPINES*DWIDTH / NUM_SPINES / NUM_SPINES*6  spine egress.
- spine_out_ready  in  NUM_SPINES  spine egress accept.
- spine_fifo_full / spine_fifo_empty  out  NUM_SPINES  ingress FIFO status.
- gpu_fifo_full / gpu_fifo_empty  out  1  GPU ingress FIFO status.
- crossbar_busy  out  1  OR of all egress valids.
- current_grant  out  GW  last GPU-egress winner; index NUM_SPINES = GPU loopback.
- drop_count  out  8  saturating misroute count.

Behaviour:
- Reset, synchronous:
  - All FIFOs empty.
  - All out_valid = 0; data/dest outputs = 0.
  - RR pointer = 0, current_grant = 0, drop_count = 0.
  - A reset mid-transfer discards all in-flight flits.
- Ingress:
  - Push when valid && ready; each entry stores {dest, data}.
  - No push while full, even if a pop happens the same cycle.
  - Head is readable the cycle after the write.
- Egress register:
  - Each egress is a register that loads when (!out_valid || out_ready) and a request is pending.
  - While out_valid && !out_ready, data and dest are held stable.
  - Minimum latency: flit accepted at edge t, out_valid high after edge t+1 (2 cycles).
  - Throughput: 1 flit/cycle/egress.
- GPU FIFO head decode:
  - dest[5:2]==GROUP_ID && dest[1:0]==ROUTER_ID: loopback request into the GPU arbiter (requester NUM_SPINES).
  - Otherwise: target spine = dest[1:0] mod NUM_SPINES. Pop when that spine's egress can load and arb_enable = 1.
  - No other source drives spine egress.
- Spine FIFO head decode:
  - Matching dest: request to the GPU arbiter.
  - Mismatching dest: popped and discarded the cycle it is at head, with no arbitration needed. drop_count increments by 1 per discard, saturating at 255.
  - Simultaneous discards on several spines in one cycle add their count, still saturating.
- GPU arbiter:
  - Round-robin over NUM_SPINES+1 requesters, starting at the RR pointer.
  - When the GPU egress loads, the winner is popped, current_grant = winner, and RR pointer = (winner+1) mod (NUM_SPINES+1).
  - With no grant, pointer and current_grant are unchanged.
- arb_enable = 0:
  - No pops and no egress loads; pending egress valids are still held.
  - Discards are also frozen.
  - Ingress pushes continue.
- Occupancy counter width is $clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package leaf_router_pkg:
  - ADDR_W = 6 and the field slices GRP_MSB/LSB = 5/2, LEAF_MSB/LSB = 1/0.
  - Function is_local(dest, grp, id).
  - Function spine_sel(dest, n).
- Sub-module sync_fifo (DWIDTH+6 wide, FIFO_DEPTH deep, first-word-valid-next-cycle), instantiated NUM_SPINES+1 times.
- The arbiter stays inline.

Test Plan:
- Loopback: GPU sends dest = {0010,11}, data 16'hA5A5, all ready = 1 -> gpu_out_valid at cycle +2 with 16'hA5A5; current_grant = 4.
- Uplink: GPU dest = {0100,10}, data 16'h1234 -> spine_out_valid[2] at +2 with dest 6'b010010; no other spine valid.
- Fairness: spines 0..3 each push 3 local flits simultaneously -> GPU output order is spine 0,1,2,3,0,1,2,3,...; 12 flits in 12 consecutive cycles.
- Backpressure: gpu_out_ready = 0 with 9 flits offered on spine 1 -> 1 flit held in the egress and 8 in the FIFO; spine_in_ready[1] = 0, spine_fifo_full[1] = 1; data is unchanged until ready returns, then all 9 arrive in order.
- Misroute: spine 0 sends 300 flits with dest {0011,00} -> no gpu_out_valid; drop_count = 255.
- Reset: assert reset while 5 flits are queued -> next cycle all FIFOs empty, all valids 0, drop_count 0, current_grant 0.
